// File: rtl/adder_pkg.sv
// Shared types and default sizes for the registered adder/accumulator.
package adder_pkg;

   typedef enum logic {
      MODE_ADD = 1'b0,
      MODE_ACC = 1'b1
   } mode_e;

   localparam int ADDER_WIDTH_DEF = 4;
   localparam int ADDER_CNT_W_DEF = 8;

endpackage

// File: rtl/adder_core.sv
// Combinational WIDTH-bit adder producing {carry, result}.
// With ADDER_ACCUM_SAT_EN defined an overflowing sum saturates to all ones.
module adder_core #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] result,
   output logic             carry
);

   logic [WIDTH:0] full_sum;

   always_comb begin
      full_sum = {1'b0, x} + {1'b0, y};
      carry    = full_sum[WIDTH];
`ifdef ADDER_ACCUM_SAT_EN
      result   = full_sum[WIDTH] ? {WIDTH{1'b1}} : full_sum[WIDTH-1:0];
`else
      result   = full_sum[WIDTH-1:0];
`endif
   end

endmodule

// File: rtl/adder_accum_pipe.sv
// Registered adder/accumulator with one output stage and valid/ready on both sides.
// Optional saturation: define ADDER_ACCUM_SAT_EN (see adder_core).
module adder_accum_pipe
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH_DEF,
   parameter int CNT_W = ADDER_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  mode_e            mode,
   input  logic             clr,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic [CNT_W-1:0] txn_cnt
);

   // Handshake: a beat transfers on a cycle where valid && ready are both high at the
   // rising edge; valid never waits on ready, and a stalled result holds every output
   // register until the consumer raises out_ready.
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;

   logic             accept;
   logic [WIDTH-1:0] acc_base;
   logic [WIDTH-1:0] op_y;
   logic [WIDTH-1:0] core_result;
   logic             core_carry;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Clear takes effect before the accumulate so clr+accept starts from zero.
   assign acc_base = clr ? '0 : acc_q;
   assign op_y     = (mode == MODE_ACC) ? acc_base : b;

   adder_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .x      (a),
      .y      (op_y),
      .result (core_result),
      .carry  (core_carry)
   );

   always_comb begin
      out_valid_d = out_valid_q;
      sum_d       = sum_q;
      carry_d     = carry_q;
      acc_d       = acc_base;
      txn_cnt_d   = txn_cnt_q;
      if (accept) begin
         out_valid_d = 1'b1;
         sum_d       = core_result;
         carry_d     = core_carry;
         txn_cnt_d   = txn_cnt_q + CNT_W'(1);
         if (mode == MODE_ACC) begin
            acc_d = core_result;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         acc_q       <= '0;
         txn_cnt_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         acc_q       <= acc_d;
         txn_cnt_q   <= txn_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign carry     = carry_q;
   assign txn_cnt   = txn_cnt_q;

endmodule
